// File: rtl/srlatch_pkg.sv
// Shared definitions for latch / flip-flop monitors: state encodings,
// synchronizer depth and the output-consistency rule for each state.
package srlatch_pkg;

    localparam int SYNC_STAGES = 2;

    localparam logic [1:0] ST_UNKNOWN = 2'd0;
    localparam logic [1:0] ST_Q0      = 2'd1;
    localparam logic [1:0] ST_Q1      = 2'd2;
    localparam logic [1:0] ST_FORBID  = 2'd3;

    // Returns 1 when the observed outputs are legal for a NOR latch in state st.
    function automatic logic state_match(input logic [1:0] st,
                                         input logic       qv,
                                         input logic       qbv);
        logic ok;
        ok = 1'b0;
        case (st)
            ST_Q0:     ok = (qv == 1'b0) && (qbv == 1'b1);
            ST_Q1:     ok = (qv == 1'b1) && (qbv == 1'b0);
            ST_FORBID: ok = (qv == 1'b0) && (qbv == 1'b0);
            default:   ok = (qv != qbv);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/srlatch_monitor_sync2.sv
// Single-bit multi-flop synchronizer, asynchronous active-high reset to 0.
module sync2
    import srlatch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] pipe;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe <= '0;
        end else begin
            pipe <= {pipe[SYNC_STAGES-2:0], d};
        end
    end

    assign q = pipe[SYNC_STAGES-1];

endmodule

// File: rtl/srlatch_monitor.sv
// SR latch checker: synchronizes latch pins, predicts the latch state and
// flags output mismatches (per episode) and forbidden s=r=1 inputs.
module srlatch_monitor
    import srlatch_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r,
    input  logic             s,
    input  logic             q,
    input  logic             q_bar,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             forbidden_seen,
    output logic             settled
);

    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYCLES);

    logic       rs, ss, qs, qbs;
    logic [1:0] prev_sr;
    logic [1:0] state;
    logic [1:0] next_state;
    logic [3:0] settle_cnt;
    logic       chg;
    logic       mismatch;
    logic       armed;

    sync2 u_sync_r    (.clk(clk), .reset(reset), .d(r),     .q(rs));
    sync2 u_sync_s    (.clk(clk), .reset(reset), .d(s),     .q(ss));
    sync2 u_sync_q    (.clk(clk), .reset(reset), .d(q),     .q(qs));
    sync2 u_sync_qbar (.clk(clk), .reset(reset), .d(q_bar), .q(qbs));

    assign chg      = ({ss, rs} != prev_sr);
    assign settled  = (settle_cnt == SETTLE_MAX) && !chg;
    assign mismatch = !state_match(state, qs, qbs);
    assign err      = settled && mismatch && armed;

    // Next latch state from the synchronized set/reset inputs.
    always_comb begin
        next_state = state;
        case ({ss, rs})
            2'b10:   next_state = ST_Q1;
            2'b01:   next_state = ST_Q0;
            2'b11:   next_state = ST_FORBID;
            default: next_state = (state == ST_FORBID) ? ST_UNKNOWN : state;
        endcase
    end

    // Expected outputs are registered from next_state so they move on the
    // same edge as the state register (2 sync edges + 1 FSM edge).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_UNKNOWN;
            prev_sr        <= '0;
            exp_q          <= 1'b0;
            exp_valid      <= 1'b0;
            forbidden_seen <= 1'b0;
        end else begin
            state     <= next_state;
            prev_sr   <= {ss, rs};
            exp_q     <= (next_state == ST_Q1);
            exp_valid <= (next_state == ST_Q0) || (next_state == ST_Q1);
            if ({ss, rs} == 2'b11) begin
                forbidden_seen <= 1'b1;
            end
        end
    end

    // Settle counter: restarts on any input change, saturates at SETTLE_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (chg) begin
            settle_cnt <= '0;
        end else if (settle_cnt != SETTLE_MAX) begin
            settle_cnt <= settle_cnt + 4'd1;
        end
    end

    // Episode tracking: one err per mismatch run; re-armed by a matching
    // settled cycle or by an input change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed <= 1'b1;
        end else if (chg) begin
            armed <= 1'b1;
        end else if (err) begin
            armed <= 1'b0;
        end else if (settled && !mismatch) begin
            armed <= 1'b1;
        end
    end

    // Saturating count of mismatch episodes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
